alu_seq_ctrl: RTL and testbench

Multi-cycle control sequencer sitting directly upstream of the 8-bit fixed-point ALU. Accepts one ALU command per valid/ready handshake, drives the ALU's five register enables and the `f_add`/`f_load` operand selects in the correct cycle order, and signals result availability to the writeback stage with a valid/ready handshake. Only one command is in flight at a time; the ALU datapath itself is not duplicated here.

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_seq_perf.sv | 31 +++
 rtl/alu_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Build option: ALU_SEQ_PERF_EN adds the retired-command/stall counters.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OPC_MAC  = 2'd0,
        OPC_ADDI = 2'd1,
        OPC_IN   = 2'd2,
        OPC_NOP  = 2'd3
    } opc_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPS  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int REN_A = 0;
    localparam int REN_B = 1;
    localparam int REN_C = 2;
    localparam int REN_D = 3;
    localparam int REN_E = 4;

    // Operand cycle loads mult A, mult B and the E register together
    localparam logic [4:0] REN_OPS_MASK = 5'b10011;

    function automatic logic [4:0] ren_bit(input int idx);
        return 5'(1) << idx;
    endfunction

endpackage

// File: rtl/alu_seq_perf.sv
// Saturating performance counter pair: retired commands and DONE stall cycles.
// Only instantiated when ALU_SEQ_PERF_EN is defined.
module alu_seq_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cmd_inc,
    input  logic        i_stall_inc,
    output logic [15:0] o_perf_cmds,
    output logic [15:0] o_perf_stall
);

    logic [15:0] r_cmds;
    logic [15:0] r_stall;

    // Count events, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmds  <= '0;
            r_stall <= '0;
        end else begin
            if (i_cmd_inc && (r_cmds != 16'hFFFF))
                r_cmds <= r_cmds + 16'd1;
            if (i_stall_inc && (r_stall != 16'hFFFF))
                r_stall <= r_stall + 16'd1;
        end
    end

    assign o_perf_cmds  = r_cmds;
    assign o_perf_stall = r_stall;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer in front of the 8-bit fixed-point ALU: one command in
// flight, drives register enables and operand selects in cycle order.
// Build option: ALU_SEQ_PERF_EN adds perf_cmds / perf_stall output ports.
//
// state | meaning
// IDLE  | ready for a command; NOP is consumed here
// OPS   | load mult A/B and E register, operands held upstream
// MUL   | multiply stages, MUL_LAT cycles (C then D, rest is settle)
// DONE  | result valid, ALU frozen until writeback accepts
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int OPC_W   = 2,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [OPC_W-1:0] cmd_opcode,
    output logic             cmd_ready,
    output logic             operand_hold,
    output logic [4:0]       reg_en,
    output logic             f_add,
    output logic             f_load,
    output logic             res_valid,
    input  logic             res_ready
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0]      perf_cmds,
    output logic [15:0]      perf_stall
`endif
);

    // MUL_LAT is at most 4, so a 2-bit stage counter covers every legal value
    localparam logic [1:0] CNT_LAST = 2'(MUL_LAT - 1);

    state_e     r_state;
    logic [1:0] r_cnt;
    logic [4:0] r_reg_en;
    logic       r_op_hold;
    logic       r_f_add;
    logic       r_f_load;
    logic       r_res_valid;
    opc_e       w_opc;

    assign w_opc = opc_e'(cmd_opcode[1:0]);

    // Sequencer FSM; every output except cmd_ready is registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_reg_en    <= '0;
            r_op_hold   <= 1'b0;
            r_f_add     <= 1'b0;
            r_f_load    <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid && (w_opc != OPC_NOP)) begin
                        r_state   <= OPS;
                        r_reg_en  <= REN_OPS_MASK;
                        r_op_hold <= 1'b1;
                        r_f_add   <= (w_opc == OPC_ADDI);
                        r_f_load  <= (w_opc == OPC_MAC);
                    end
                end
                OPS: begin
                    r_state   <= MUL;
                    r_cnt     <= '0;
                    r_reg_en  <= ren_bit(REN_C);
                    r_op_hold <= 1'b0;
                end
                MUL: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= DONE;
                        r_reg_en    <= '0;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_cnt    <= r_cnt + 2'd1;
                        // stage 1 loads D; later stages only let the ALU settle
                        r_reg_en <= (r_cnt == 2'd0) ? ren_bit(REN_D) : 5'b00000;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                        r_f_add     <= 1'b0;
                        r_f_load    <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_reg_en    <= '0;
                    r_op_hold   <= 1'b0;
                    r_f_add     <= 1'b0;
                    r_f_load    <= 1'b0;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready    = (r_state == IDLE);
    assign operand_hold = r_op_hold;
    assign reg_en       = r_reg_en;
    assign f_add        = r_f_add;
    assign f_load       = r_f_load;
    assign res_valid    = r_res_valid;

`ifdef ALU_SEQ_PERF_EN
    logic w_retire;
    logic w_stall;

    // A command retires when its result is taken, or immediately if it is a NOP
    assign w_retire = ((r_state == DONE) && res_ready) ||
                      ((r_state == IDLE) && cmd_valid && (w_opc == OPC_NOP));
    assign w_stall  = (r_state == DONE) && !res_ready;

    alu_seq_perf u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cmd_inc    (w_retire),
        .i_stall_inc  (w_stall),
        .o_perf_cmds  (perf_cmds),
        .o_perf_stall (perf_stall)
    );
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl (MUL_LAT=2 instance plus a MUL_LAT=4 instance).
module tb_alu_seq_ctrl;

    localparam int LAT  = 2;
    localparam int LAT4 = 4;

    logic       clk;
    logic       rst_n;

    logic       cmd_valid;
    logic [1:0] cmd_opcode;
    logic       cmd_ready;
    logic       operand_hold;
    logic [4:0] reg_en;
    logic       f_add;
    logic       f_load;
    logic       res_valid;
    logic       res_ready;

    logic       cmd_valid4;
    logic [1:0] cmd_opcode4;
    logic       cmd_ready4;
    logic       operand_hold4;
    logic [4:0] reg_en4;
    logic       f_add4;
    logic       f_load4;
    logic       res_valid4;
    logic       res_ready4;

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] perf_cmds;
    logic [15:0] perf_stall;
    logic [15:0] perf_cmds4;
    logic [15:0] perf_stall4;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [1:0] opc;
        logic       fa;
        logic       fl;
        int         acc;   // value of cyc right after the accepting edge
    } exp_t;

    typedef struct {
        logic [1:0] opc;
        int         stall;
        logic       fa;
        logic       fl;
    } vec_t;

    exp_t sb2[$];
    exp_t sb4[$];
    vec_t vecs[6];

    alu_seq_ctrl #(.OPC_W(2), .MUL_LAT(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_opcode   (cmd_opcode),
        .cmd_ready    (cmd_ready),
        .operand_hold (operand_hold),
        .reg_en       (reg_en),
        .f_add        (f_add),
        .f_load       (f_load),
        .res_valid    (res_valid),
        .res_ready    (res_ready)
`ifdef ALU_SEQ_PERF_EN
        ,
        .perf_cmds    (perf_cmds),
        .perf_stall   (perf_stall)
`endif
    );

    alu_seq_ctrl #(.OPC_W(2), .MUL_LAT(LAT4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid4),
        .cmd_opcode   (cmd_opcode4),
        .cmd_ready    (cmd_ready4),
        .operand_hold (operand_hold4),
        .reg_en       (reg_en4),
        .f_add        (f_add4),
        .f_load       (f_load4),
        .res_valid    (res_valid4),
        .res_ready    (res_ready4)
`ifdef ALU_SEQ_PERF_EN
        ,
        .perf_cmds    (perf_cmds4),
        .perf_stall   (perf_stall4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboards: pop on each rising res_valid and check selects, latency, frozen enables
    logic rv_prev  = 1'b0;
    logic rv4_prev = 1'b0;
    exp_t e2;
    exp_t e4;

    always @(negedge clk) begin
        if (rst_n && res_valid && !rv_prev) begin
            if (sb2.size() == 0) begin
                chk("sb2_unexpected_result", 32'(res_valid), 0);
            end else begin
                e2 = sb2.pop_front();
                chk("sb2_f_add", 32'(f_add), 32'(e2.fa));
                chk("sb2_f_load", 32'(f_load), 32'(e2.fl));
                chk("sb2_latency", cyc - e2.acc, LAT + 1);
                chk("sb2_done_ren", 32'(reg_en), 0);
            end
        end
        rv_prev <= res_valid;
    end

    always @(negedge clk) begin
        if (rst_n && res_valid4 && !rv4_prev) begin
            if (sb4.size() == 0) begin
                chk("sb4_unexpected_result", 32'(res_valid4), 0);
            end else begin
                e4 = sb4.pop_front();
                chk("sb4_f_add", 32'(f_add4), 32'(e4.fa));
                chk("sb4_f_load", 32'(f_load4), 32'(e4.fl));
                chk("sb4_latency", cyc - e4.acc, LAT4 + 1);
                chk("sb4_done_ren", 32'(reg_en4), 0);
            end
        end
        rv4_prev <= res_valid4;
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_cmd_ready", 32'(cmd_ready), 1);
    endtask

    // One command on the MUL_LAT=2 instance with a cycle-by-cycle trace check
    task automatic run_cmd(input logic [1:0] opc, input int stall, input logic fa, input logic fl);
`ifdef ALU_SEQ_PERF_EN
        logic [15:0] pc0;
        logic [15:0] ps0;
`endif
        wait_ready();
`ifdef ALU_SEQ_PERF_EN
        pc0 = perf_cmds;
        ps0 = perf_stall;
`endif
        cmd_valid  = 1'b1;
        cmd_opcode = opc;
        res_ready  = 1'b0;
        if (opc != 2'd3) sb2.push_back('{opc, fa, fl, cyc + 1});
        @(negedge clk);
        cmd_valid = 1'b0;
        if (opc == 2'd3) begin
            for (int i = 0; i < 3; i++) begin
                chk("nop_reg_en", 32'(reg_en), 0);
                chk("nop_res_valid", 32'(res_valid), 0);
                chk("nop_cmd_ready", 32'(cmd_ready), 1);
                @(negedge clk);
            end
`ifdef ALU_SEQ_PERF_EN
            chk("nop_perf_cmds", 32'(perf_cmds), 32'(pc0) + 1);
`endif
            return;
        end
        chk("ops_reg_en", 32'(reg_en), 32'h13);
        chk("ops_hold", 32'(operand_hold), 1);
        chk("ops_f_add", 32'(f_add), 32'(fa));
        chk("ops_f_load", 32'(f_load), 32'(fl));
        chk("ops_cmd_ready", 32'(cmd_ready), 0);
        @(negedge clk);
        chk("mul0_reg_en", 32'(reg_en), 32'h04);
        chk("mul0_hold", 32'(operand_hold), 0);
        chk("mul0_cmd_ready", 32'(cmd_ready), 0);
        @(negedge clk);
        chk("mul1_reg_en", 32'(reg_en), 32'h08);
        @(negedge clk);
        chk("done_res_valid", 32'(res_valid), 1);
        chk("done_cmd_ready", 32'(cmd_ready), 0);
        for (int i = 0; i < stall; i++) begin
            chk("stall_res_valid", 32'(res_valid), 1);
            chk("stall_reg_en", 32'(reg_en), 0);
            chk("stall_f_add", 32'(f_add), 32'(fa));
            chk("stall_f_load", 32'(f_load), 32'(fl));
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("exit_res_valid", 32'(res_valid), 0);
        chk("exit_cmd_ready", 32'(cmd_ready), 1);
        chk("exit_f_add", 32'(f_add), 0);
        chk("exit_f_load", 32'(f_load), 0);
`ifdef ALU_SEQ_PERF_EN
        chk("perf_cmds_inc", 32'(perf_cmds), 32'(pc0) + 1);
        chk("perf_stall_inc", 32'(perf_stall), 32'(ps0) + 32'(stall));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;

        //           opcode  stall fa    fl
        vecs[0] = '{2'd0, 0, 1'b0, 1'b1};  // MAC
        vecs[1] = '{2'd1, 5, 1'b1, 1'b0};  // ADDI, 5 stall cycles in DONE
        vecs[2] = '{2'd2, 0, 1'b0, 1'b0};  // IN
        vecs[3] = '{2'd3, 0, 1'b0, 1'b0};  // NOP
        vecs[4] = '{2'd0, 2, 1'b0, 1'b1};  // MAC
        vecs[5] = '{2'd1, 1, 1'b1, 1'b0};  // ADDI

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_opcode  = 2'd0;
        res_ready   = 1'b0;
        cmd_valid4  = 1'b0;
        cmd_opcode4 = 2'd0;
        res_ready4  = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_reg_en", 32'(reg_en), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_reg_en", 32'(reg_en), 0);
        chk("post_rst_f_add", 32'(f_add), 0);
        chk("post_rst_f_load", 32'(f_load), 0);
        chk("post_rst_res_valid", 32'(res_valid), 0);
        chk("post_rst_hold", 32'(operand_hold), 0);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
`ifdef ALU_SEQ_PERF_EN
        chk("post_rst_perf_cmds", 32'(perf_cmds), 0);
        chk("post_rst_perf_stall", 32'(perf_stall), 0);
`endif

        // early res_ready must not matter
        res_ready = 1'b1;
        @(negedge clk);
        chk("early_ready_res_valid", 32'(res_valid), 0);
        res_ready = 1'b0;

        for (int v = 0; v < 6; v++)
            run_cmd(vecs[v].opc, vecs[v].stall, vecs[v].fa, vecs[v].fl);

        // cmd_valid held through a busy command: the IN must wait for IDLE
        wait_ready();
        res_ready  = 1'b1;
        cmd_valid  = 1'b1;
        cmd_opcode = 2'd0;
        t0 = cyc + 1;
        sb2.push_back('{2'd0, 1'b0, 1'b1, cyc + 1});
        @(negedge clk);
        cmd_opcode = 2'd2;
        chk("held_mac_f_load", 32'(f_load), 1);
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("held_in_ready", 32'(cmd_ready), 1);
        chk("held_in_spacing", cyc + 1 - t0, LAT + 3);
        sb2.push_back('{2'd2, 1'b0, 1'b0, cyc + 1});
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("held_in_ops_reg_en", 32'(reg_en), 32'h13);
        chk("held_in_f_load", 32'(f_load), 0);
        chk("held_in_f_add", 32'(f_add), 0);
        wait_ready();
        res_ready = 1'b0;

        // reset pulse mid-MUL clears outputs without a clock edge
        cmd_valid  = 1'b1;
        cmd_opcode = 2'd0;
        sb2.push_back('{2'd0, 1'b0, 1'b1, cyc + 1});
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_abort_reg_en", 32'(reg_en), 32'h04);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_reg_en", 32'(reg_en), 0);
        chk("abort_f_load", 32'(f_load), 0);
        chk("abort_f_add", 32'(f_add), 0);
        chk("abort_res_valid", 32'(res_valid), 0);
        chk("abort_hold", 32'(operand_hold), 0);
        chk("abort_cmd_ready", 32'(cmd_ready), 1);
        sb2.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef ALU_SEQ_PERF_EN
        chk("abort_perf_cmds", 32'(perf_cmds), 0);
`endif
        run_cmd(2'd1, 0, 1'b1, 1'b0);

        // MUL_LAT=4 instance: two settle cycles with no enables
        cmd_valid4  = 1'b1;
        cmd_opcode4 = 2'd0;
        sb4.push_back('{2'd0, 1'b0, 1'b1, cyc + 1});
        @(negedge clk);
        cmd_valid4 = 1'b0;
        chk("l4_ops_reg_en", 32'(reg_en4), 32'h13);
        @(negedge clk);
        chk("l4_mul0_reg_en", 32'(reg_en4), 32'h04);
        @(negedge clk);
        chk("l4_mul1_reg_en", 32'(reg_en4), 32'h08);
        @(negedge clk);
        chk("l4_mul2_reg_en", 32'(reg_en4), 0);
        chk("l4_mul2_res_valid", 32'(res_valid4), 0);
        @(negedge clk);
        chk("l4_mul3_reg_en", 32'(reg_en4), 0);
        chk("l4_mul3_res_valid", 32'(res_valid4), 0);
        @(negedge clk);
        chk("l4_done_res_valid", 32'(res_valid4), 1);
        n = 0;
        while (!cmd_ready4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("l4_back_to_idle", 32'(cmd_ready4), 1);

        repeat (2) @(negedge clk);
        chk("sb2_drained", 32'(sb2.size()), 0);
        chk("sb4_drained", 32'(sb4.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
